// File: rtl/dsp_mac_if.sv
// Operand/result bundle between the input register blocks and the DSP MAC stage.
// master drives operands and observes results; slave is the arithmetic stage.
interface dsp_mac_if #(
    parameter int AB_WIDTH = 18,
    parameter int C_WIDTH  = 48
);
    logic                in_valid;
    logic [AB_WIDTH-1:0] a;
    logic [AB_WIDTH-1:0] b;
    logic [AB_WIDTH-1:0] d;
    logic [C_WIDTH-1:0]  c;
    logic [4:0]          opmode;
    logic                acc_clr;
    logic [C_WIDTH-1:0]  p;
    logic                carry_out;
    logic                out_valid;

    modport master (
        output in_valid, a, b, d, c, opmode, acc_clr,
        input  p, carry_out, out_valid
    );

    modport slave (
        input  in_valid, a, b, d, c, opmode, acc_clr,
        output p, carry_out, out_valid
    );
endinterface

// File: rtl/dsp_mac_stage.sv
// Pre-adder -> signed multiplier -> post-adder/accumulator, three pipeline stages
// with a valid bit travelling alongside the data.
module dsp_mac_stage #(
    parameter int AB_WIDTH = 18,
    parameter int C_WIDTH  = 48,
    parameter bit PREG     = 1'b1
) (
    input  logic     clk,
    input  logic     reset,
    dsp_mac_if.slave bus
);
    localparam int M_WIDTH = 2 * AB_WIDTH;

    typedef struct packed {
        logic carry_in;
        logic post_sub;
        logic acc_sel;
    } post_op_t;

    // ---------------- Stage 1: pre-adder ----------------
    logic [AB_WIDTH-1:0] pre_next;
    post_op_t            op_in;

    // NOTE: every variable written in always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        pre_next = bus.b;
        if (bus.opmode[0]) begin
            pre_next = bus.opmode[1] ? bus.d - bus.b : bus.d + bus.b;
        end
    end

    assign op_in = '{carry_in: bus.opmode[4], post_sub: bus.opmode[3], acc_sel: bus.opmode[2]};

    logic                       v1;
    logic signed [AB_WIDTH-1:0] a1;
    logic signed [AB_WIDTH-1:0] pre1;
    logic [C_WIDTH-1:0]         c1;
    post_op_t                   op1;

    // NOTE: sequential state uses non-blocking assignments so all stages sample pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            v1   <= 1'b0;
            a1   <= '0;
            pre1 <= '0;
            c1   <= '0;
            op1  <= '0;
        end else begin
            v1   <= bus.in_valid;
            a1   <= bus.a;
            pre1 <= pre_next;
            c1   <= bus.c;
            op1  <= op_in;
        end
    end

    // ---------------- Stage 2: multiplier ----------------
    logic signed [M_WIDTH-1:0] m_full;
    assign m_full = M_WIDTH'(a1) * M_WIDTH'(pre1);

    logic               v2;
    logic [C_WIDTH-1:0] m2;
    logic [C_WIDTH-1:0] c2;
    post_op_t           op2;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            v2  <= 1'b0;
            m2  <= '0;
            c2  <= '0;
            op2 <= '0;
        end else begin
            v2  <= v1;
            m2  <= {{(C_WIDTH-M_WIDTH){m_full[M_WIDTH-1]}}, m_full};
            c2  <= c1;
            op2 <= op1;
        end
    end

    // ---------------- Stage 3: post-adder / accumulator ----------------
    logic [C_WIDTH-1:0] z;
    logic [C_WIDTH:0]   x_ext;
    logic [C_WIDTH:0]   z_ext;
    logic [C_WIDTH:0]   cin_ext;
    logic [C_WIDTH:0]   sum;
    logic [C_WIDTH-1:0] acc_q;
    logic               co_q;

    // Z is taken as an unsigned 48-bit quantity and the product keeps its sign into bit 48,
    // so bit 48 reports unsigned carry on C/P overflow and borrow when Z is below X+cin.
    always_comb begin
        z       = bus.acc_clr ? '0 : (op2.acc_sel ? acc_q : c2);
        z_ext   = {1'b0, z};
        x_ext   = {m2[C_WIDTH-1], m2};
        cin_ext = (C_WIDTH+1)'(op2.carry_in);
        sum     = op2.post_sub ? z_ext - (x_ext + cin_ext) : z_ext + x_ext + cin_ext;
    end

    // The accumulator only moves on a valid result or an idle-cycle clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc_q <= '0;
            co_q  <= 1'b0;
        end else if (v2) begin
            acc_q <= sum[C_WIDTH-1:0];
            co_q  <= sum[C_WIDTH];
        end else if (bus.acc_clr) begin
            acc_q <= '0;
            co_q  <= 1'b0;
        end
    end

    generate
        if (PREG) begin : g_preg
            logic ov_q;

            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    ov_q <= 1'b0;
                end else begin
                    ov_q <= v2;
                end
            end

            assign bus.p         = acc_q;
            assign bus.carry_out = co_q;
            assign bus.out_valid = ov_q;
        end else begin : g_comb
            assign bus.p         = v2 ? sum[C_WIDTH-1:0] : acc_q;
            assign bus.carry_out = v2 ? sum[C_WIDTH] : co_q;
            assign bus.out_valid = v2;
        end
    endgenerate
endmodule

// File: tb/tb_dsp_mac_stage.sv
// Self-checking bench for dsp_mac_stage (PREG=1): directed vectors, hand-written
// accumulate/clear/reset sequences, and random traffic against a cycle-level model.
module tb_dsp_mac_stage;
    localparam int NRAND = 400;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    dsp_mac_if #(.AB_WIDTH(18), .C_WIDTH(48)) bus ();

    dsp_mac_stage #(.AB_WIDTH(18), .C_WIDTH(48), .PREG(1'b1)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        v;
        logic [17:0] a;
        logic [17:0] b;
        logic [17:0] d;
        logic [47:0] c;
        logic [4:0]  op;
        logic        clr;
    } stim_t;

    typedef struct {
        string       name;
        stim_t       s;
        logic [47:0] exp_p;
        logic        exp_co;
    } vec_t;

    vec_t  vecs[6];
    stim_t hist[NRAND];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic stim_t mk(input logic v, input logic [17:0] a, input logic [17:0] b,
                                 input logic [17:0] d, input logic [47:0] c,
                                 input logic [4:0] op, input logic clr);
        stim_t s;
        s.v = v; s.a = a; s.b = b; s.d = d; s.c = c; s.op = op; s.clr = clr;
        return s;
    endfunction

    task automatic apply(input stim_t s);
        bus.in_valid = s.v;
        bus.a        = s.a;
        bus.b        = s.b;
        bus.d        = s.d;
        bus.c        = s.c;
        bus.opmode   = s.op;
        bus.acc_clr  = s.clr;
    endtask

    task automatic idle();
        apply(mk(1'b0, '0, '0, '0, '0, '0, 1'b0));
    endtask

    // Reference arithmetic: plain integers, result reduced modulo 2^49.
    function automatic logic [48:0] mac_sum(input logic [17:0] a, input logic [17:0] b,
                                            input logic [17:0] d, input logic [47:0] zin,
                                            input logic [4:0] op);
        longint            da, db, pre_i, prod, zv, cin, s;
        logic signed [17:0] pre18;
        da    = longint'($signed(d));
        db    = longint'($signed(b));
        pre_i = op[0] ? (op[1] ? da - db : da + db) : db;
        pre18 = pre_i[17:0];
        prod  = longint'($signed(a)) * longint'(pre18);
        zv    = longint'({16'h0, zin});
        cin   = op[4] ? 64'sd1 : 64'sd0;
        s     = op[3] ? zv - (prod + cin) : zv + prod + cin;
        return s[48:0];
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [47:0] acc_m;
        logic        co_m;
        logic        ov_m;
        logic [48:0] s;
        logic [47:0] zin;
        stim_t       st;

        vecs[0] = '{"pre_add",      mk(1'b1, 18'd3,       18'd2,  18'd5,       48'd10,  5'b00001, 1'b0), 48'd31,            1'b0};
        vecs[1] = '{"post_sub_cin", mk(1'b1, 18'h3FFFC,   18'd7,  18'd0,       48'd0,   5'b11000, 1'b0), 48'd27,            1'b0};
        vecs[2] = '{"c_carry",      mk(1'b1, 18'd1,       18'd1,  18'd0,       48'hFFFF_FFFF_FFFF, 5'b00000, 1'b0), 48'd0, 1'b1};
        vecs[3] = '{"pre_wrap",     mk(1'b1, 18'h3FFFF,   18'd1,  18'h1FFFF,   48'd0,   5'b00001, 1'b0), 48'h0000_0002_0000, 1'b0};
        vecs[4] = '{"pre_sub",      mk(1'b1, 18'h3FFFB,   18'd10, 18'd3,       48'd100, 5'b00011, 1'b0), 48'd135,           1'b0};
        vecs[5] = '{"sub_borrow",   mk(1'b1, 18'd2,       18'd3,  18'd0,       48'd5,   5'b01000, 1'b0), 48'hFFFF_FFFF_FFFF, 1'b1};

        // Reset state
        reset = 1'b0;
        idle();
        repeat (2) @(posedge clk);
        #1;
        check("reset_p", bus.p, 0);
        check("reset_co", bus.carry_out, 0);
        check("reset_ov", bus.out_valid, 0);
        #2 reset = 1'b1;
        step();

        // Directed single-sample vectors: 3-edge latency, one-cycle out_valid, p held after
        foreach (vecs[i]) begin
            apply(vecs[i].s);
            step();
            idle();
            step();
            check({vecs[i].name, "_early_ov"}, bus.out_valid, 0);
            step();
            check({vecs[i].name, "_p"}, bus.p, vecs[i].exp_p);
            check({vecs[i].name, "_co"}, bus.carry_out, vecs[i].exp_co);
            check({vecs[i].name, "_ov"}, bus.out_valid, 1);
            step();
            check({vecs[i].name, "_ov_drop"}, bus.out_valid, 0);
            check({vecs[i].name, "_p_hold"}, bus.p, vecs[i].exp_p);
        end

        // Reset mid-stream with two samples in flight
        apply(vecs[0].s);
        step();
        step();
        idle();
        #2 reset = 1'b0;
        #1;
        check("midrst_p", bus.p, 0);
        check("midrst_co", bus.carry_out, 0);
        check("midrst_ov", bus.out_valid, 0);
        @(posedge clk);
        #3 reset = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            check($sformatf("midrst_quiet_ov[%0d]", k), bus.out_valid, 0);
            check($sformatf("midrst_quiet_p[%0d]", k), bus.p, 0);
        end

        // Clear, then four back-to-back accumulating valids: p = 1,2,3,4
        for (int k = 0; k < 8; k++) begin
            if (k == 0)      apply(mk(1'b0, 0, 0, 0, 0, 5'b00000, 1'b1));
            else if (k <= 4) apply(mk(1'b1, 18'd1, 18'd1, 0, 48'd999, 5'b00100, 1'b0));
            else             idle();
            step();
            if (k >= 3 && k <= 6) begin
                check($sformatf("accum_p[%0d]", k), bus.p, k - 2);
                check($sformatf("accum_ov[%0d]", k), bus.out_valid, 1);
            end
            if (k == 7) begin
                check("accum_end_ov", bus.out_valid, 0);
                check("accum_end_p", bus.p, 4);
            end
        end

        // Accumulate three, clear-and-load the fourth, then clear on an idle cycle
        for (int k = 0; k < 8; k++) begin
            if (k == 0)      apply(mk(1'b0, 0, 0, 0, 0, 5'b00000, 1'b1));
            else if (k <= 3) apply(mk(1'b1, 18'd1, 18'd1, 0, 0, 5'b00100, 1'b0));
            else if (k == 4) apply(mk(1'b1, 18'd2, 18'd5, 0, 0, 5'b00100, 1'b0));
            else if (k >= 6) apply(mk(1'b0, 0, 0, 0, 0, 5'b00000, 1'b1));
            else             idle();
            step();
            if (k == 5) check("clrload_pre_p", bus.p, 3);
            if (k == 6) begin
                check("clrload_p", bus.p, 10);
                check("clrload_ov", bus.out_valid, 1);
            end
            if (k == 7) begin
                check("idleclr_p", bus.p, 0);
                check("idleclr_ov", bus.out_valid, 0);
            end
        end

        // Random traffic against the cycle-level model
        idle();
        reset = 1'b0;
        @(posedge clk);
        #3 reset = 1'b1;
        step();
        acc_m = '0;
        co_m  = 1'b0;
        for (int k = 0; k < NRAND; k++) begin
            st.v   = ($urandom_range(3, 0) != 0);
            st.a   = 18'($urandom());
            st.b   = 18'($urandom());
            st.d   = 18'($urandom());
            st.c   = {16'($urandom()), $urandom()};
            st.op  = 5'($urandom());
            st.clr = ($urandom_range(7, 0) == 0);
            hist[k] = st;
            apply(st);
            step();
            ov_m = 1'b0;
            if (k >= 2 && hist[k-2].v) begin
                zin   = hist[k].clr ? 48'd0 : (hist[k-2].op[2] ? acc_m : hist[k-2].c);
                s     = mac_sum(hist[k-2].a, hist[k-2].b, hist[k-2].d, zin, hist[k-2].op);
                acc_m = s[47:0];
                co_m  = s[48];
                ov_m  = 1'b1;
            end else if (hist[k].clr) begin
                acc_m = '0;
                co_m  = 1'b0;
            end
            check($sformatf("rand_ov[%0d]", k), bus.out_valid, ov_m);
            check($sformatf("rand_p[%0d]", k), bus.p, acc_m);
            check($sformatf("rand_co[%0d]", k), bus.carry_out, co_m);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
